// File: rtl/filter_accel_div_seq.sv
// Radix-2 restoring signed-by-unsigned divider, one quotient bit per clock, fixed DIVIDEND_W+1 cycle issue rate.
// Define FILTER_ACCEL_DIV_DBZ_FLAG_EN to add the registered divide-by-zero flag output dbz.
module filter_accel_div_seq #(
  parameter int ID         = 1,
  parameter int DIVIDEND_W = 19,
  parameter int DIVISOR_W  = 11,
  parameter int REM_W      = 12
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         start,
  input  logic signed [DIVIDEND_W-1:0] din0,
  input  logic        [DIVISOR_W-1:0]  din1,
  output logic                         ready,
  output logic                         done,
  output logic signed [DIVIDEND_W-1:0] quot,
  output logic signed [REM_W-1:0]      rem
`ifdef FILTER_ACCEL_DIV_DBZ_FLAG_EN
  ,
  output logic                         dbz
`endif
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  if (REM_W != DIVISOR_W + 1) begin : g_bad_rem_w
    $error("filter_accel_div_seq: REM_W must equal DIVISOR_W+1");
  end
  if (ID < 0) begin : g_bad_id
    $error("filter_accel_div_seq: ID must be non-negative");
  end

  state_t                       state_q;
  logic                         ready_q;
  logic                         done_q;
  logic                         sign_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [DIVIDEND_W-1:0]        mag_q;
  logic [DIVISOR_W-1:0]         div_q;
  logic [REM_W-1:0]             part_q;
  logic signed [DIVIDEND_W-1:0] quot_q;
  logic signed [REM_W-1:0]      rem_q;
`ifdef FILTER_ACCEL_DIV_DBZ_FLAG_EN
  logic                         dbz_q;
`endif

  logic [DIVIDEND_W-1:0]        mag_in;
  logic [REM_W:0]               part_wide;
  logic                         fits;
  logic [REM_W-1:0]             part_d;
  logic [DIVIDEND_W-1:0]        mag_d;
  logic signed [DIVIDEND_W-1:0] quot_d;
  logic signed [REM_W-1:0]      rem_d;

  // mag_q doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom.
  always_comb begin
    mag_in    = din0[DIVIDEND_W-1] ? DIVIDEND_W'(-din0) : DIVIDEND_W'(din0);
    part_wide = {part_q, mag_q[DIVIDEND_W-1]};
    fits      = (part_wide >= (REM_W+1)'(div_q));
    part_d    = fits ? REM_W'(part_wide - (REM_W+1)'(div_q)) : REM_W'(part_wide);
    mag_d     = {mag_q[DIVIDEND_W-2:0], fits};
    if (div_q == '0) begin
      quot_d = sign_q ? {1'b1, {(DIVIDEND_W-1){1'b0}}} : {1'b0, {(DIVIDEND_W-1){1'b1}}};
      rem_d  = '0;
    end else begin
      quot_d = sign_q ? -$signed(mag_d) : $signed(mag_d);
      rem_d  = sign_q ? -$signed(part_d) : $signed(part_d);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      mag_q   <= '0;
      div_q   <= '0;
      part_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef FILTER_ACCEL_DIV_DBZ_FLAG_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (start && ready_q) begin
        // ready_q is high only in IDLE and DONE, so this covers both accept paths
        state_q <= S_CALC;
        ready_q <= 1'b0;
        sign_q  <= din0[DIVIDEND_W-1];
        mag_q   <= mag_in;
        div_q   <= din1;
        part_q  <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_CALC: begin
            mag_q  <= mag_d;
            part_q <= part_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
              state_q <= S_DONE;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
              quot_q  <= quot_d;
              rem_q   <= rem_d;
`ifdef FILTER_ACCEL_DIV_DBZ_FLAG_EN
              dbz_q   <= (div_q == '0);
`endif
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign quot  = quot_q;
  assign rem   = rem_q;
`ifdef FILTER_ACCEL_DIV_DBZ_FLAG_EN
  assign dbz   = dbz_q;
`endif

endmodule

// File: doc/filter_accel_div_seq.md
Name: filter_accel_div_seq

Overview:
Sequential signed-by-unsigned integer divider for the filter_accel datapath. It is the inverse of the 8x11 signed/unsigned multiplier stage and rescales accumulated filter products back to sample range. It uses a radix-2 restoring algorithm, produces one quotient bit per clock, and has a fixed latency so the HLS schedule can treat it as a multi-cycle operator.

Parameters:
ID, 1, instance identifier; no functional effect.
DIVIDEND_W, 19, width of the signed dividend and of the signed quotient.
DIVISOR_W, 11, width of the unsigned divisor.
REM_W, 12, width of the signed remainder; must equal DIVISOR_W+1.

Ports:
ap_clk  in  1  clock; all state changes on the rising edge.
ap_rst  in  1  synchronous, active-high reset.
start  in  1  request; operands are sampled on a rising edge where start=1 and ready=1.
din0  in  DIVIDEND_W  signed dividend.
din1  in  DIVISOR_W  unsigned divisor.
ready  out  1  block can accept start this cycle.
done  out  1  one-cycle pulse; quot and rem are valid from this cycle on.
quot  out  DIVIDEND_W  signed quotient, truncated toward zero.
rem  out  REM_W  signed remainder; its sign follows the dividend.

Behaviour:
- Reset: while ap_rst=1 at a clock edge, FSM goes to IDLE; ready=1, done=0, quot=0, rem=0, iteration counter=0. Reset aborts any operation in flight; no done pulse is issued for the aborted operation.
- States:
  - IDLE: ready=1. On start, go to CALC.
  - CALC: ready=0. Runs DIVIDEND_W iterations, then goes to DONE.
  - DONE: ready=1, done=1 for exactly this cycle. If start=1, go directly to CALC (back-to-back operation); otherwise go to IDLE.
- Accept (edge T):
  - Latch the dividend sign and |din0| as an unsigned DIVIDEND_W-bit magnitude. |-2^18| = 2^18 fits.
  - Latch din1; clear the partial remainder (DIVISOR_W+1 bits); counter=0.
- CALC iteration (one per cycle):
  - Shift {partial remainder, magnitude} left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - Increment the counter; after DIVIDEND_W iterations, go to DONE.
- Latency:
  - done=1 in the cycle after edge T+DIVIDEND_W (20 cycles after accept for the defaults). Latency is fixed and independent of operand values, including divide-by-zero.
- Result on entry to DONE:
  - quot = sign ? -Q : Q; rem = sign ? -R : R.
  - quot and rem hold until the next DONE or reset; they do not change during a following CALC.
- Divide by zero (din1=0):
  - Iterations still run, but the result is forced on entry to DONE.
  - quot = 2^(DIVIDEND_W-1)-1 if the dividend is >= 0, else -2^(DIVIDEND_W-1); rem=0.
- start while in CALC: ignored; no queuing.
- start held high continuously: one operation per DIVIDEND_W+1 cycles.
- Operand changes after accept have no effect.

Optional Feature:
FILTER_ACCEL_DIV_DBZ_FLAG_EN
- Defined: adds output port dbz (1 bit). dbz is reset to 0, updated on entry to DONE to (latched divisor == 0), and held with quot and rem.
- Undefined: the port does not exist. Saturating divide-by-zero behaviour is unchanged.

Test Plan:
- Reset then idle -> ready=1, done=0, quot=0, rem=0. Then start with din0=1000, din1=7 -> done exactly 20 cycles after accept, quot=142, rem=6.
- din0=-1000, din1=7 -> quot=-142, rem=-6. Then din0=-262144, din1=1 -> quot=-262144, rem=0.
- din0=262143, din1=2047 -> quot=128, rem=127. Then din0=5, din1=11 -> quot=0, rem=5.
- din0=5, din1=0 -> quot=262143, rem=0 (dbz=1 if enabled). Then din0=-5, din1=0 -> quot=-262144, rem=0.
- Back-to-back: start held high with a new operand accepted in the DONE cycle -> a second done pulse 20 cycles later. start pulses during CALC are ignored (no extra done, results unchanged).
- Assert ap_rst for 1 cycle at iteration 10 -> outputs return to 0, no done pulse. A fresh 1000/7 then completes correctly.
